// File: rtl/stepper_step_gen.sv
// stepper_step_gen: per-axis step/direction/enable generator with valid/ready move intake.
// Define STEPPER_ACCEL_EN to build the trapezoidal speed ramp.
module stepper_step_gen #(
   parameter int PERIOD_W     = 16,
   parameter int PULSE_W      = 2,
   parameter int DIR_SETUP    = 4,
   parameter int HOLD_CLKS    = 100,
   parameter int START_PERIOD = 200,
   parameter int ACCEL_DEC    = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [31:0]         cmd_steps,
   input  logic [PERIOD_W-1:0] cmd_period,
   input  logic                abort,
   output logic                stepper_enable,
   output logic                stepper_step,
   output logic                stepper_direction,
   output logic                busy,
   output logic                done,
   output logic [31:0]         steps_left
);

   localparam int CW = (PERIOD_W > 16) ? PERIOD_W : 16;
   localparam int HW = (HOLD_CLKS > 0) ? $clog2(HOLD_CLKS + 1) : 1;
   localparam logic [CW-1:0]       SETUP_LD = CW'(DIR_SETUP - 1);
   localparam logic [CW-1:0]       PULSE_LD = CW'(PULSE_W - 1);
   localparam logic [PERIOD_W-1:0] MIN_PER  = PERIOD_W'(2 * PULSE_W);
   localparam logic [PERIOD_W-1:0] LOW_SUB  = PERIOD_W'(PULSE_W + 1);
   localparam logic [HW-1:0]       HOLD_LD  = HW'(HOLD_CLKS);

   if (PULSE_W < 1 || DIR_SETUP < 1 || HOLD_CLKS < 0 ||
       START_PERIOD < 1 || ACCEL_DEC < 0) begin : g_bad_params
      $error("stepper_step_gen: invalid parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_DONE
   } state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [PERIOD_W-1:0] eff_period;
   logic [PERIOD_W-1:0] cur_period;
   logic [HW-1:0]       hold_cnt;
   logic                abort_pend;
   logic                moved;

   logic [31:0]         abs_steps;
   logic [PERIOD_W-1:0] req_period;
   logic [CW-1:0]       low_ld;
   logic                accept_mv;
   logic                rise_setup;
   logic                rise_low;

   assign abs_steps  = cmd_steps[31] ? (~cmd_steps + 32'd1) : cmd_steps;
   assign req_period = (cmd_period < MIN_PER) ? MIN_PER : cmd_period;
   assign low_ld     = CW'(cur_period - LOW_SUB);

   assign accept_mv  = (state == S_IDLE) && cmd_valid && (abs_steps != '0);
   assign rise_setup = (state == S_SETUP) && !abort && (cnt == '0);
   assign rise_low   = (state == S_LOW) && !abort && (cnt == '0) &&
                       (steps_left != '0);

`ifdef STEPPER_ACCEL_EN
   localparam logic [PERIOD_W-1:0] START_PER = PERIOD_W'(START_PERIOD);
   localparam logic [PERIOD_W-1:0] DEC_PER   = PERIOD_W'(ACCEL_DEC);

   logic [PERIOD_W-1:0] ramp_period;
   logic [31:0]         ramp_cnt;
   logic [PERIOD_W-1:0] first_per;
   logic [PERIOD_W-1:0] top_per;
   logic [PERIOD_W:0]   up_sum;
   logic [PERIOD_W:0]   down_lim;
   logic [PERIOD_W-1:0] up_per;
   logic [PERIOD_W-1:0] down_per;
   logic [PERIOD_W-1:0] next_per;
   logic                decel;

   assign first_per = (START_PER > req_period) ? START_PER : req_period;
   assign top_per   = (START_PER > eff_period) ? START_PER : eff_period;
   assign up_sum    = {1'b0, ramp_period} + {1'b0, DEC_PER};
   assign down_lim  = {1'b0, eff_period} + {1'b0, DEC_PER};
   assign up_per    = (up_sum > {1'b0, top_per}) ? top_per
                                                 : up_sum[PERIOD_W-1:0];
   assign down_per  = ({1'b0, ramp_period} >= down_lim)
                    ? (ramp_period - DEC_PER) : eff_period;
   // Braking starts once the remaining steps match the steps spent ramping up.
   assign decel     = (steps_left <= ramp_cnt);
   assign next_per  = decel ? up_per : down_per;
   assign cur_period = ramp_period;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ramp_period <= '0;
         ramp_cnt    <= '0;
      end else if (accept_mv) begin
         ramp_period <= first_per;
         ramp_cnt    <= '0;
      end else if (rise_setup) begin
         if (ramp_period > eff_period)
            ramp_cnt <= ramp_cnt + 32'd1;
      end else if (rise_low) begin
         ramp_period <= next_per;
         if (!decel && (next_per > eff_period))
            ramp_cnt <= ramp_cnt + 32'd1;
      end
   end
`else
   assign cur_period = eff_period;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state             <= S_IDLE;
         cnt               <= '0;
         eff_period        <= '0;
         hold_cnt          <= '0;
         abort_pend        <= 1'b0;
         moved             <= 1'b0;
         cmd_ready         <= 1'b1;
         busy              <= 1'b0;
         done              <= 1'b0;
         steps_left        <= '0;
         stepper_step      <= 1'b0;
         stepper_direction <= 1'b0;
         stepper_enable    <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (!accept_mv) begin
                     state      <= S_DONE;
                     done       <= 1'b1;
                     moved      <= 1'b0;
                     steps_left <= '0;
                  end else begin
                     state             <= S_SETUP;
                     cnt               <= SETUP_LD;
                     steps_left        <= abs_steps;
                     stepper_direction <= cmd_steps[31];
                     stepper_enable    <= 1'b0;
                     eff_period        <= req_period;
                     abort_pend        <= 1'b0;
                     hold_cnt          <= '0;
                     moved             <= 1'b1;
                  end
               end else if (hold_cnt == HW'(1)) begin
                  hold_cnt       <= '0;
                  stepper_enable <= 1'b1;
               end else if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            S_SETUP: begin
               if (abort) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (rise_setup) begin
                  state        <= S_HIGH;
                  stepper_step <= 1'b1;
                  steps_left   <= steps_left - 32'd1;
                  cnt          <= PULSE_LD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_HIGH: begin
               // An abort never shortens a pulse already on the wire.
               if (abort)
                  abort_pend <= 1'b1;
               if (cnt == '0) begin
                  stepper_step <= 1'b0;
                  if (abort || abort_pend) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_LOW;
                     cnt   <= low_ld;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_LOW: begin
               if (rise_low) begin
                  state        <= S_HIGH;
                  stepper_step <= 1'b1;
                  steps_left   <= steps_left - 32'd1;
                  cnt          <= PULSE_LD;
               end else if (abort || (cnt == '0)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               if (moved) begin
                  if (HOLD_CLKS == 0)
                     stepper_enable <= 1'b1;
                  else
                     hold_cnt <= HOLD_LD;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stepper_step_gen.sv
// tb_stepper_step_gen: vector table plus hand-written corner sequences,
// with a step/done scoreboard fed by the driver.
module tb_stepper_step_gen;

   localparam int PERIOD_W = 16;
   localparam int PULSE_W  = 2;
   localparam int DS       = 4;
   localparam int HOLD     = 100;

   logic                clk;
   logic                reset_n;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [31:0]         cmd_steps;
   logic [PERIOD_W-1:0] cmd_period;
   logic                abort;
   logic                stepper_enable;
   logic                stepper_step;
   logic                stepper_direction;
   logic                busy;
   logic                done;
   logic [31:0]         steps_left;

   stepper_step_gen #(
      .PERIOD_W(PERIOD_W),
      .PULSE_W(PULSE_W),
      .DIR_SETUP(DS),
      .HOLD_CLKS(HOLD),
      .START_PERIOD(20),
      .ACCEL_DEC(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_steps(cmd_steps),
      .cmd_period(cmd_period),
      .abort(abort),
      .stepper_enable(stepper_enable),
      .stepper_step(stepper_step),
      .stepper_direction(stepper_direction),
      .busy(busy),
      .done(done),
      .steps_left(steps_left)
   );

   typedef struct {
      longint cyc;
      bit     dir;
   } rise_t;

   typedef struct {
      int steps;
      int period;
      bit dir;
      int gap;
      int done_off;
   } vec_t;

   int     total = 0;
   int     bad = 0;
   int     done_cnt = 0;
   longint cyc = 0;
   longint pos = 0;
   longint rise_cyc = 0;
   logic   prev_step = 1'b0;
   rise_t  exp_rise[$];
   longint exp_done[$];
   rise_t  mr;
   longint md;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every step rise and done pulse.
   always @(posedge clk) begin
      #1;
      if (!reset_n) begin
         exp_rise.delete();
         exp_done.delete();
         prev_step = 1'b0;
      end else begin
         if (stepper_step && !prev_step) begin
            check("step_while_enabled", longint'(stepper_enable), 0);
            check("step_expected", longint'(exp_rise.size() != 0), 1);
            if (exp_rise.size() != 0) begin
               mr = exp_rise.pop_front();
               check("rise_cyc", cyc, mr.cyc);
               check("rise_dir", longint'(stepper_direction), longint'(mr.dir));
            end
            if (stepper_direction) pos = pos - 1;
            else pos = pos + 1;
            rise_cyc = cyc;
         end
         if (!stepper_step && prev_step)
            check("pulse_width", cyc - rise_cyc, PULSE_W);
         if (done) begin
            done_cnt++;
            check("done_expected", longint'(exp_done.size() != 0), 1);
            if (exp_done.size() != 0) begin
               md = exp_done.pop_front();
               if (md >= 0) check("done_cyc", cyc, md);
            end
         end
         prev_step = stepper_step;
      end
   end

   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   task automatic exp_step(input longint c, input bit d);
      rise_t r;
      r.cyc = c;
      r.dir = d;
      exp_rise.push_back(r);
   endtask

   task automatic drive_cmd(input logic [31:0] s, input int p);
      cmd_valid  = 1'b1;
      cmd_steps  = s;
      cmd_period = PERIOD_W'(p);
      sync();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int limit);
      int n;
      n = 0;
      while (done_cnt == d0 && n < limit) begin
         sync();
         n++;
      end
      check("done_seen", done_cnt - d0, 1);
   endtask

   task automatic check_idle();
      sync();
      check("idle_ready", longint'(cmd_ready), 1);
      check("idle_busy", longint'(busy), 0);
      check("idle_done", longint'(done), 0);
   endtask

`ifndef STEPPER_ACCEL_EN
   vec_t vecs[6];

   task automatic run_vec(input vec_t v);
      longint a;
      longint p0;
      int     n;
      int     d0;
      n  = (v.steps < 0) ? -v.steps : v.steps;
      p0 = pos;
      d0 = done_cnt;
      sync();
      a = cyc + 1;
      for (int k = 0; k < n; k++) exp_step(a + DS + k * v.gap, v.dir);
      exp_done.push_back(a + v.done_off);
      drive_cmd(v.steps, v.period);
      check("acc_busy", longint'(busy), 1);
      check("acc_ready", longint'(cmd_ready), 0);
      check("acc_enable", longint'(stepper_enable), 0);
      if (n != 0) begin
         check("acc_steps_left", longint'(steps_left), n);
         check("acc_dir", longint'(stepper_direction), longint'(v.dir));
      end
      wait_done(d0, v.done_off + 40);
      check("end_steps_left", longint'(steps_left), 0);
      check("end_position", pos - p0, v.steps);
      check("rises_missing", exp_rise.size(), 0);
      check_idle();
   endtask

   task automatic abort_high();
      longint a;
      int     d0;
      d0 = done_cnt;
      sync();
      a = cyc + 1;
      exp_step(a + DS, 1'b0);
      exp_step(a + DS + 10, 1'b0);
      exp_done.push_back(a + DS + 10 + PULSE_W);
      drive_cmd(10, 10);
      repeat (DS + 10) sync();
      check("abort_in_high", longint'(stepper_step), 1);
      abort = 1'b1;
      sync();
      abort = 1'b0;
      wait_done(d0, 10);
      check("abort_high_left", longint'(steps_left), 8);
      check("abort_high_rises", exp_rise.size(), 0);
      check_idle();
   endtask

   task automatic abort_low();
      longint a;
      int     d0;
      d0 = done_cnt;
      sync();
      a = cyc + 1;
      exp_step(a + DS, 1'b0);
      exp_done.push_back(a + DS + 4);
      drive_cmd(4, 10);
      repeat (DS + 3) sync();
      abort = 1'b1;
      sync();
      abort = 1'b0;
      wait_done(d0, 10);
      check("abort_low_left", longint'(steps_left), 3);
      check_idle();
   endtask

   task automatic abort_last();
      longint a;
      int     d0;
      d0 = done_cnt;
      sync();
      a = cyc + 1;
      exp_step(a + DS, 1'b0);
      exp_done.push_back(a + DS + 10);
      drive_cmd(1, 10);
      repeat (DS + 9) sync();
      abort = 1'b1;
      sync();
      abort = 1'b0;
      wait_done(d0, 10);
      repeat (3) sync();
      check("abort_last_single_done", done_cnt - d0, 1);
      check("abort_last_left", longint'(steps_left), 0);
   endtask

   task automatic abort_setup_and_hold();
      longint a;
      longint dcyc;
      int     d0;
      d0 = done_cnt;
      sync();
      a = cyc + 1;
      exp_done.push_back(a + 1);
      drive_cmd(32'h8000_0000, 10);
      check("min_int_left", longint'(steps_left), 64'h8000_0000);
      check("min_int_dir", longint'(stepper_direction), 1);
      abort = 1'b1;
      sync();
      abort = 1'b0;
      wait_done(d0, 10);
      dcyc = cyc;
      check("setup_abort_left", longint'(steps_left), 64'h8000_0000);
      check_idle();
      repeat (int'(dcyc + HOLD - cyc)) sync();
      check("hold_enable_low", longint'(stepper_enable), 0);
      sync();
      check("hold_enable_high", longint'(stepper_enable), 1);
   endtask

   task automatic zero_released();
      int d0;
      d0 = done_cnt;
      sync();
      exp_done.push_back(cyc + 1);
      drive_cmd(0, 10);
      check("zero_enable_kept", longint'(stepper_enable), 1);
      wait_done(d0, 5);
      sync();
      check("zero_enable_after", longint'(stepper_enable), 1);
   endtask

   task automatic reset_mid_high();
      longint a;
      int     d0;
      d0 = done_cnt;
      sync();
      a = cyc + 1;
      exp_step(a + DS, 1'b0);
      exp_step(a + DS + 10, 1'b0);
      exp_step(a + DS + 20, 1'b0);
      drive_cmd(3, 10);
      repeat (DS) sync();
      check("pre_reset_high", longint'(stepper_step), 1);
      reset_n = 1'b0;
      sync();
      check("rst_step", longint'(stepper_step), 0);
      check("rst_enable", longint'(stepper_enable), 1);
      check("rst_busy", longint'(busy), 0);
      check("rst_ready", longint'(cmd_ready), 1);
      check("rst_left", longint'(steps_left), 0);
      reset_n = 1'b1;
      repeat (30) sync();
      check("rst_no_done", done_cnt - d0, 0);
      check("rst_no_step", longint'(stepper_step), 0);
   endtask
`else
   task automatic accel_ramp();
      int     gaps[7];
      longint a;
      longint t;
      longint p0;
      int     d0;
      gaps = '{20, 16, 12, 8, 8, 12, 16};
      p0 = pos;
      d0 = done_cnt;
      sync();
      a = cyc + 1;
      t = a + DS;
      exp_step(t, 1'b0);
      for (int k = 0; k < 7; k++) begin
         t = t + gaps[k];
         exp_step(t, 1'b0);
      end
      exp_done.push_back(-1);
      drive_cmd(8, 8);
      check("ramp_acc_enable", longint'(stepper_enable), 0);
      check("ramp_acc_left", longint'(steps_left), 8);
      wait_done(d0, 300);
      check("ramp_rises", exp_rise.size(), 0);
      check("ramp_position", pos - p0, 8);
      check("ramp_left", longint'(steps_left), 0);
      check_idle();
   endtask
`endif

   initial begin
      reset_n    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_steps  = '0;
      cmd_period = '0;
      abort      = 1'b0;
`ifndef STEPPER_ACCEL_EN
      vecs[0] = '{3, 10, 1'b0, 10, 34};
      vecs[1] = '{-5, 8, 1'b1, 8, 44};
      vecs[2] = '{0, 10, 1'b0, 0, 0};
      vecs[3] = '{2, 1, 1'b0, 4, 12};
      vecs[4] = '{1, 4, 1'b0, 4, 8};
      vecs[5] = '{-1, 3, 1'b1, 4, 8};
`endif
      repeat (3) @(posedge clk);
      #2;
      check("reset_ready", longint'(cmd_ready), 1);
      check("reset_busy", longint'(busy), 0);
      check("reset_done", longint'(done), 0);
      check("reset_step", longint'(stepper_step), 0);
      check("reset_dir", longint'(stepper_direction), 0);
      check("reset_enable", longint'(stepper_enable), 1);
      check("reset_left", longint'(steps_left), 0);
      reset_n = 1'b1;
`ifndef STEPPER_ACCEL_EN
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);
      abort_high();
      abort_low();
      abort_last();
      abort_setup_and_hold();
      zero_released();
      reset_mid_high();
`else
      accel_ramp();
`endif
      repeat (3) sync();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
